// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a stable synchronized lock, then releases sys_reset.
// Define PLL_SEQ_STATS_EN to add the loss_cnt output (lock-loss events seen while running).
module pll_lock_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 500000,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned CW            = 20
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       req_reset,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic       fail,
   output logic [1:0] retry_cnt,
   output logic [2:0] state
`ifdef PLL_SEQ_STATS_EN
   ,
   output logic [7:0] loss_cnt
`endif
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_SETTLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } st_t;

   localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
   localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

   st_t           st, st_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    retry_n;
   logic          lk_meta, lk;
`ifdef PLL_SEQ_STATS_EN
   logic          loss_hit;
`endif

   always_comb begin
      st_n    = st;
      retry_n = retry_cnt;
`ifdef PLL_SEQ_STATS_EN
      loss_hit = 1'b0;
`endif
      if (req_reset) begin
         st_n = S_PLL_RST;
         if (st == S_FAIL) retry_n = '0;
      end else begin
         case (st)
            S_PLL_RST:
               if (cnt == RST_LAST) st_n = S_WAIT_LOCK;
            S_WAIT_LOCK:
               if (lk) st_n = S_SETTLE;
               else if (cnt == TIMEOUT_LAST) begin
                  if (retry_cnt == RETRY_MAX) st_n = S_FAIL;
                  else begin
                     st_n    = S_PLL_RST;
                     retry_n = retry_cnt + 2'd1;
                  end
               end
            S_SETTLE:
               if (!lk) st_n = S_WAIT_LOCK;
               else if (cnt == SETTLE_LAST) begin
                  st_n    = S_RUN;
                  retry_n = '0;
               end
            S_RUN:
               if (!lk) begin
                  st_n = S_PLL_RST;
`ifdef PLL_SEQ_STATS_EN
                  loss_hit = 1'b1;
`endif
               end
            S_FAIL:  st_n = S_FAIL;
            default: st_n = S_PLL_RST;
         endcase
      end

      // req_reset in PLL_RST keeps the state but must still restart the pulse
      if (st_n != st || req_reset || st == S_RUN || st == S_FAIL) cnt_n = '0;
      else                                                        cnt_n = cnt + CW'(1);
   end

   // Outputs are registered from the next state so they line up exactly with st
   always_ff @(posedge refclk) begin
      if (rst) begin
         lk_meta   <= 1'b0;
         lk        <= 1'b0;
         st        <= S_PLL_RST;
         cnt       <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
         fail      <= 1'b0;
         state     <= 3'd0;
`ifdef PLL_SEQ_STATS_EN
         loss_cnt  <= '0;
`endif
      end else begin
         lk_meta   <= pll_locked;
         lk        <= lk_meta;
         st        <= st_n;
         cnt       <= cnt_n;
         retry_cnt <= retry_n;
         pll_rst   <= (st_n == S_PLL_RST);
         sys_reset <= (st_n != S_RUN);
         ready     <= (st_n == S_RUN);
         fail      <= (st_n == S_FAIL);
         state     <= st_n;
`ifdef PLL_SEQ_STATS_EN
         if (loss_hit && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
`endif
      end
   end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the video/system PLL: drives the PLL reset, waits for a stable lock, and releases the downstream system reset only after lock has been continuously stable.
- Recovers from lock loss by re-resetting the PLL, with a bounded retry count and a terminal fail flag.
- Runs on the 50 MHz reference clock, alongside the PLL instance in the top-level clocking block.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per PLL reset attempt (≥2).
- LOCK_TIMEOUT, 500000: cycles to wait for lock after pll_rst release before a retry (10 ms at 50 MHz).
- SETTLE_CYCLES, 1024: cycles lock must stay continuously high before ready.
- MAX_RETRIES, 3: timeout retries permitted before FAIL.
- CW, 20: internal cycle counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)-1.

Ports:
- refclk  in  1  sole clock, 50 MHz reference.
- rst  in  1  synchronous, active-high reset.
- req_reset  in  1  single-cycle request to restart the full PLL sequence (from OSD/HPS).
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- pll_rst  out  1  reset to the PLL.
- sys_reset  out  1  reset for downstream logic; high unless in RUN.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  2  timeout retries used in the current sequence.
- state  out  3  current state encoding, for debug.

Behaviour:
- Interface: one clock, refclk; reset rst is synchronous and active-high.
- Synchronizer: pll_locked passes through a 2-FF synchronizer to give lk; both flops reset to 0.
- Decode: all outputs decode from registered state, counter and retry_cnt; there are no combinational paths from inputs to outputs.
- rst: state=PLL_RST, cnt=0, retry_cnt=0.
  - Outputs in the cycle after rst: pll_rst=1, sys_reset=1, ready=0, fail=0.
- State encoding: PLL_RST=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAIL=4.
- PLL_RST: pll_rst=1 for exactly RST_CYCLES cycles; lk is ignored.
  - When cnt==RST_CYCLES-1, go to WAIT_LOCK with cnt=0.
- WAIT_LOCK: pll_rst=0.
  - lk=1: go to SETTLE with cnt=0.
  - Else, when cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES go to FAIL; otherwise retry_cnt+1 and go to PLL_RST.
- SETTLE: pll_rst=0.
  - lk=0: go back to WAIT_LOCK with cnt=0 (fresh timeout, no retry consumed).
  - When cnt==SETTLE_CYCLES-1: go to RUN and clear retry_cnt.
  - ready rises exactly SETTLE_CYCLES cycles after SETTLE entry.
- RUN: sys_reset=0, ready=1.
  - lk=0 or req_reset=1: go to PLL_RST with cnt=0; sys_reset re-asserts on the next cycle.
  - Both conditions in the same cycle: single transition to PLL_RST.
- FAIL: pll_rst=0, sys_reset=1, fail=1.
  - Exits only on rst, or on req_reset (go to PLL_RST, retry_cnt=0).
- req_reset in any other state: go to PLL_RST, cnt=0, retry_cnt unchanged. It takes precedence over every other transition except rst.
- Counter: cnt clears on every state change and never wraps; each state exits at or before its terminal count.
- rst during any state, including mid-pulse: immediate return to reset values. The pll_rst pulse restarts with its full RST_CYCLES length.

Optional Feature:
- Macro PLL_SEQ_STATS_EN.
- Defined: adds output loss_cnt [7:0].
  - Counts RUN→PLL_RST transitions caused by lk=0; req_reset-initiated transitions do not count.
  - Saturates at 255 and is cleared only by rst.
- Undefined: no port and no counter; behaviour is otherwise identical.

Test Plan:
- Reset, then lk rises 100 cycles after pll_rst falls and stays high → pll_rst high exactly 16 cycles; ready and sys_reset=0 exactly 1024 cycles after SETTLE entry; retry_cnt=0.
- pll_locked never rises → 3 retries, each with a 16-cycle pll_rst pulse; fail=1 after the 4th timeout; sys_reset stays 1.
- In SETTLE, lk drops at cnt=500 and rises again → return to WAIT_LOCK, then SETTLE restarts at 0; retry_cnt unchanged; ready only after a full 1024 stable cycles.
- In RUN, drop pll_locked → within 3 cycles sys_reset=1 and pll_rst pulses 16 cycles; relock returns to RUN; loss_cnt=1 (with PLL_SEQ_STATS_EN).
- In FAIL, pulse req_reset → PLL_RST, retry_cnt=0, fail=0; simultaneous lk drop and req_reset in RUN → one PLL_RST entry, loss_cnt unchanged.
- Assert rst at cycle 8 of a pll_rst pulse → the pulse restarts at full 16-cycle length; all outputs at reset values.
